// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO controller: arbitrary depth, occupancy count, programmable almost flags, guarded over/underflow.
// Define FIFO_SYNC_OUT_REG_EN for a registered rdata output (1-cycle read latency); default is first-word-fall-through.
module fifo_sync_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wren,
  input  logic                  rden,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head;

  logic [PTR_W-1:0] wrptr_q, wrptr_d;
  logic [PTR_W-1:0] rdptr_q, rdptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok, rd_ok;

  // All status flags decode the single registered count.
  always_comb begin
    full         = (count_q == CNT_FULL);
    empty        = (count_q == '0);
    almost_full  = (count_q >= CNT_AF);
    almost_empty = (count_q <= CNT_AE);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // A write into a full FIFO is still accepted when a read frees the head slot on the same edge.
  always_comb begin
    wr_ok = wren & (~full | rden);
    rd_ok = rden & ~empty;
  end

  always_comb begin
    wrptr_d     = wrptr_q;
    rdptr_d     = rdptr_q;
    count_d     = count_q;
    overflow_d  = wren & ~wr_ok;
    underflow_d = rden & ~rd_ok;

    if (wr_ok) begin
      wrptr_d = (wrptr_q == PTR_LAST) ? '0 : wrptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rdptr_d = (rdptr_q == PTR_LAST) ? '0 : rdptr_q + PTR_W'(1);
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrptr_q     <= wrptr_d;
      rdptr_q     <= rdptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; stale words stay hidden behind empty.
  always_ff @(posedge clk) begin
    if (rstn && wr_ok) begin
      mem_q[wrptr_q] <= wdata;
    end
  end

  always_comb begin
    head = mem_q[rdptr_q];
  end

`ifdef FIFO_SYNC_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_ok) begin
      rdata_d = head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    rdata = rdata_q;
  end
`else
  always_comb begin
    rdata = empty ? '0 : head;
  end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl (DEPTH=5, AF=4, AE=1); works in both the FWFT and registered-output builds.
module tb_fifo_sync_ctrl;

  logic        clk;
  logic        rstn;
  logic        wren;
  logic        rden;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  fifo_sync_ctrl #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (5),
    .AF_LEVEL   (4),
    .AE_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wren         (wren),
    .rden         (rden),
    .wdata        (wdata),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cnt;
    bit          f;
    bit          e;
    bit          af;
    bit          ae;
    bit          ov;
    bit          un;
    logic [31:0] rd;
  } st_t;

  typedef struct {
    string       name;
    logic [31:0] v;
  } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  done   = 1'b0;
  bit  rd_pend = 1'b0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    st_t s;
    rd_t r;
`ifdef FIFO_SYNC_OUT_REG_EN
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", rdata, 32'hffff_ffff);
      end else begin
        r = rd_q.pop_front();
        check({"rdata_", r.name}, rdata, r.v);
      end
    end
    rd_pend = rstn && rden && !empty;
`else
    if (rstn && rden && !empty) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", rdata, 32'hffff_ffff);
      end else begin
        r = rd_q.pop_front();
        check({"rdata_", r.name}, rdata, r.v);
      end
    end
`endif
    while (st_q.size() != 0) begin
      s = st_q.pop_front();
      check({s.name, ".count"},        32'(count),        32'(s.cnt));
      check({s.name, ".full"},         32'(full),         32'(s.f));
      check({s.name, ".empty"},        32'(empty),        32'(s.e));
      check({s.name, ".almost_full"},  32'(almost_full),  32'(s.af));
      check({s.name, ".almost_empty"}, 32'(almost_empty), 32'(s.ae));
      check({s.name, ".overflow"},     32'(overflow),     32'(s.ov));
      check({s.name, ".underflow"},    32'(underflow),    32'(s.un));
      check({s.name, ".rdata"},        rdata,             s.rd);
    end
    if (done) begin
      check("pending_reads", 32'(rd_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic exp_st(input string n, input int c, input bit f, input bit e, input bit af,
                        input bit ae, input bit ov, input bit un,
                        input logic [31:0] rd_fwft, input logic [31:0] rd_reg);
    st_t s;
    s.name = n; s.cnt = c; s.f = f; s.e = e; s.af = af; s.ae = ae; s.ov = ov; s.un = un;
`ifdef FIFO_SYNC_OUT_REG_EN
    s.rd = rd_reg;
`else
    s.rd = rd_fwft;
`endif
    st_q.push_back(s);
  endtask

  task automatic exp_rd(input string n, input logic [31:0] v);
    rd_t r;
    r.name = n; r.v = v;
    rd_q.push_back(r);
  endtask

  task automatic cyc(input bit w, input bit r, input logic [31:0] d);
    wren = w; rden = r; wdata = d;
    @(posedge clk);
    #1;
    wren = 1'b0; rden = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; wren = 1'b1; rden = 1'b0; wdata = 32'h99;
    repeat (2) @(posedge clk);
    #1;
    exp_st("reset", 0, 0,1,0,1, 0,0, 32'h0, 32'h0);
    rstn = 1'b1; wren = 1'b0;

    // Fill to full
    cyc(1,0,32'hA0); exp_st("wr_a0", 1, 0,0,0,1, 0,0, 32'hA0, 32'h0);
    cyc(1,0,32'hA1); exp_st("wr_a1", 2, 0,0,0,0, 0,0, 32'hA0, 32'h0);
    cyc(1,0,32'hA2); exp_st("wr_a2", 3, 0,0,0,0, 0,0, 32'hA0, 32'h0);
    cyc(1,0,32'hA3); exp_st("wr_a3", 4, 0,0,1,0, 0,0, 32'hA0, 32'h0);
    cyc(1,0,32'hA4); exp_st("wr_a4", 5, 1,0,1,0, 0,0, 32'hA0, 32'h0);

    // Rejected write into full FIFO
    cyc(1,0,32'hDEAD); exp_st("ovf",     5, 1,0,1,0, 1,0, 32'hA0, 32'h0);
    cyc(0,0,32'h0);    exp_st("ovf_clr", 5, 1,0,1,0, 0,0, 32'hA0, 32'h0);

    exp_rd("a0", 32'hA0); cyc(0,1,32'h0); exp_st("rd_a0", 4, 0,0,1,0, 0,0, 32'hA1, 32'hA0);
    exp_rd("a1", 32'hA1); cyc(0,1,32'h0); exp_st("rd_a1", 3, 0,0,0,0, 0,0, 32'hA2, 32'hA1);
    exp_rd("a2", 32'hA2); cyc(0,1,32'h0); exp_st("rd_a2", 2, 0,0,0,0, 0,0, 32'hA3, 32'hA2);

    // Write pointer wraps through slot 0
    cyc(1,0,32'hB0); exp_st("wr_b0", 3, 0,0,0,0, 0,0, 32'hA3, 32'hA2);
    cyc(1,0,32'hB1); exp_st("wr_b1", 4, 0,0,1,0, 0,0, 32'hA3, 32'hA2);
    cyc(1,0,32'hB2); exp_st("wr_b2", 5, 1,0,1,0, 0,0, 32'hA3, 32'hA2);

    // Full with simultaneous read and write
    exp_rd("a3", 32'hA3); cyc(1,1,32'h22); exp_st("full_both", 5, 1,0,1,0, 0,0, 32'hA4, 32'hA3);

    exp_rd("a4", 32'hA4); cyc(0,1,32'h0); exp_st("rd_a4", 4, 0,0,1,0, 0,0, 32'hB0, 32'hA4);
    exp_rd("b0", 32'hB0); cyc(0,1,32'h0); exp_st("rd_b0", 3, 0,0,0,0, 0,0, 32'hB1, 32'hB0);
    exp_rd("b1", 32'hB1); cyc(0,1,32'h0); exp_st("rd_b1", 2, 0,0,0,0, 0,0, 32'hB2, 32'hB1);
    exp_rd("b2", 32'hB2); cyc(0,1,32'h0); exp_st("rd_b2", 1, 0,0,0,1, 0,0, 32'h22, 32'hB2);
    exp_rd("22", 32'h22); cyc(0,1,32'h0); exp_st("rd_22", 0, 0,1,0,1, 0,0, 32'h0,  32'h22);

    // Underflow, then empty with simultaneous read and write
    cyc(0,1,32'h0);  exp_st("unf",        0, 0,1,0,1, 0,1, 32'h0,  32'h22);
    cyc(1,1,32'h11); exp_st("empty_both", 1, 0,0,0,1, 0,1, 32'h11, 32'h22);
    cyc(0,0,32'h0);  exp_st("unf_clr",    1, 0,0,0,1, 0,0, 32'h11, 32'h22);
    exp_rd("11", 32'h11); cyc(0,1,32'h0); exp_st("rd_11", 0, 0,1,0,1, 0,0, 32'h0, 32'h11);

    // Read latency / hold behaviour
    cyc(1,0,32'h33); exp_st("wr_33", 1, 0,0,0,1, 0,0, 32'h33, 32'h11);
    cyc(1,0,32'h44); exp_st("wr_44", 2, 0,0,0,0, 0,0, 32'h33, 32'h11);
    exp_rd("33", 32'h33); cyc(0,1,32'h0); exp_st("rd_33", 1, 0,0,0,1, 0,0, 32'h44, 32'h33);
    cyc(0,0,32'h0);  exp_st("hold",  1, 0,0,0,1, 0,0, 32'h44, 32'h33);
    exp_rd("44", 32'h44); cyc(0,1,32'h0); exp_st("rd_44", 0, 0,1,0,1, 0,0, 32'h0, 32'h44);

    // Reset in the middle of traffic
    cyc(1,0,32'h55); exp_st("wr_55", 1, 0,0,0,1, 0,0, 32'h55, 32'h44);
    rstn = 1'b0; wren = 1'b1; rden = 1'b1; wdata = 32'h66;
    @(posedge clk);
    #1;
    rstn = 1'b1; wren = 1'b0; rden = 1'b0;
    exp_st("mid_reset", 0, 0,1,0,1, 0,0, 32'h0, 32'h0);
    done = 1'b1;
  end

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Next-generation synchronous FIFO for the TPU data path. It generalises the earlier pointer-compare FIFO in four ways:
- any depth is allowed, not only powers of two;
- an explicit occupancy count is provided;
- almost-full and almost-empty thresholds are programmable;
- writes into a full FIFO and reads from an empty one are guarded and flagged.

It sits between feeders and the systolic-array edge buffers, where back-pressure needs early warning.

Parameters:
DATA_WIDTH, 32, data bit width (>=1)
FIFO_DEPTH, 8, number of entries (>=2, any integer)
AF_LEVEL, FIFO_DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..FIFO_DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..FIFO_DEPTH-1)
Derived (localparam): PTR_W = max(1, $clog2(FIFO_DEPTH)), CNT_W = $clog2(FIFO_DEPTH+1)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, synchronous, active-low
wren  input  1  write request
rden  input  1  read request
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  head-of-queue data
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CNT_W  current occupancy
overflow  output  1  one-cycle pulse: previous cycle's write was rejected
underflow  output  1  one-cycle pulse: previous cycle's read was rejected

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rstn), sampled on the rising edge of clk.
- Reset values:
  - wrptr = 0, rdptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, rdata = 0.
  - Storage array is not reset.
- Acceptance rules, evaluated on the current state before the edge:
  - wr_ok = wren & (!full | rden)
  - rd_ok = rden & !empty
- Simultaneous events:
  - Full with both wren and rden: both are accepted; count is unchanged.
  - Empty with both: the write is accepted, the read is rejected (underflow); count becomes 1.
- Pointers:
  - wrptr and rdptr are PTR_W-bit indices that increment on wr_ok / rd_ok respectively.
  - Each wraps explicitly from FIFO_DEPTH-1 to 0; there is no modulo-2^n aliasing.
- Count update: count_next = count + wr_ok - rd_ok. It is a single registered counter and the only source for the full, empty, almost_full and almost_empty flags.
- Flag timing: all four status flags are combinational decodes of the registered count, so they change in the same cycle count changes.
- Write path: mem[wrptr] <= wdata on wr_ok.
- Read path (default, first-word-fall-through):
  - rdata = mem[rdptr] when !empty, otherwise all-zeros.
  - rd_ok consumes the head; the next entry appears after the edge.
- Error flags:
  - overflow <= wren & !wr_ok
  - underflow <= rden & !rd_ok
  - Both are registered, high for exactly one cycle per rejected request.
  - A rejected request changes no pointer, count or memory contents.
- Reset mid-operation: a low rstn on any edge returns every register to its reset value regardless of wren/rden. Stale memory contents are unobservable because empty = 1.
- Latency:
  - Write to visible on rdata: 1 cycle (the written word appears after the edge when the FIFO was empty).
  - Flags: same-edge update.

Optional Feature:
Macro FIFO_SYNC_OUT_REG_EN.
- Defined:
  - rdata is a register that loads mem[rdptr] on the edge where rd_ok is true, giving 1-cycle read latency.
  - rdata holds its value otherwise, including when empty. Reset value is 0.
  - Flag and count behaviour is identical to the default.
- Undefined: FWFT combinational rdata as described under Behaviour.

Test Plan:
- Reset: DEPTH=5, AF=4, AE=1. Drive rstn low for 2 edges with wren=1 → count=0, empty=1, almost_empty=1, full=0, overflow=0, rdata=0.
- Fill and wrap: DEPTH=5. Write 0xA0..0xA4, then read 3, then write 0xB0..0xB2 → wrptr wraps 4→0. Reading 5 words returns 0xA3, 0xA4, 0xB0, 0xB1, 0xB2. almost_full is high at count 4 and 5; full is high only at count 5.
- Overflow: with the FIFO full (5 entries), pulse wren with wdata=0xDEAD for 1 cycle → overflow=1 for exactly the next cycle, count stays 5, and 0xDEAD is never read out.
- Underflow and empty-simultaneous: on an empty FIFO assert wren+rden with wdata=0x11 → next cycle count=1, underflow=1, rdata=0x11 (default build).
- Full-simultaneous: with the FIFO full, assert wren+rden with wdata=0x22 → count stays 5, overflow=0, the head advances, and 0x22 is read out last.
- FIFO_SYNC_OUT_REG_EN build: write 0x33, 0x44, then assert rden for one cycle → rdata=0x33 appears one edge after the read and holds until the next read.
